// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down counter / one-shot timer with single-cycle done pulse
//
// Optional auto-reload on expiry: define DOWN_COUNTER_AUTO_RELOAD_EN.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enable     count enable (decrement only while high)
//   load       synchronous load strobe, priority over enable
//   load_value start value captured on load
//   out        current count (registered)
//   zero       out==0 and not running (registered)
//   busy       counter running (registered)
//   done       one-cycle pulse on expiry (registered)

module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_d;
    logic             zero_d;
    logic             busy_d;
    logic             done_d;
    logic             expire;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_value;
        end
    end
`endif

    // A load in the same cycle discards the pending expiry.
    // RUN always holds a non-zero count, so <= ONE only ever sees 1.
    assign expire = !load && (state_q == RUN) && enable && (out <= CNT_ONE);

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            out     <= '0;
            zero    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            out     <= out_d;
            zero    <= zero_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state and next count
    always_comb begin
        state_d = state_q;
        out_d   = out;
        if (load) begin
            out_d   = load_value;
            state_d = (load_value != CNT_ZERO) ? RUN : DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    out_d = CNT_ZERO;
                end
                RUN: begin
                    if (expire) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        out_d   = reload_q;
                        state_d = RUN;
`else
                        out_d   = CNT_ZERO;
                        state_d = DONE;
`endif
                    end else if (enable) begin
                        out_d = out - CNT_ONE;
                    end
                end
                DONE: begin
                    out_d = CNT_ZERO;
                end
                default: begin
                    out_d   = CNT_ZERO;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Next output flags, derived from the next state so they land with the count
    always_comb begin
        busy_d = (state_d == RUN);
        zero_d = (out_d == CNT_ZERO) && (state_d != RUN);
        done_d = expire;
    end

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - self-checking bench for down_counter

module tb_down_counter;

    typedef struct {
        logic       ld;
        logic       en;
        logic [7:0] lv;
        logic [7:0] eo;
        logic       ez;
        logic       eb;
        logic       ed;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic [7:0] out;
    logic       zero;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    vec_t sb[$];
    vec_t tbl[$];

    down_counter #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .out        (out),
        .zero       (zero),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic ld, logic en, logic [7:0] lv,
                                logic [7:0] eo, logic ez, logic eb, logic ed);
        vec_t v;
        v.ld = ld; v.en = en; v.lv = lv;
        v.eo = eo; v.ez = ez; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic check_pop(input string name);
        vec_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            checks += 4;
            if (out !== e.eo) begin
                errors++;
                $display("FAIL %s out: got %0d want %0d", name, out, e.eo);
            end
            if (zero !== e.ez) begin
                errors++;
                $display("FAIL %s zero: got %b want %b", name, zero, e.ez);
            end
            if (busy !== e.eb) begin
                errors++;
                $display("FAIL %s busy: got %b want %b", name, busy, e.eb);
            end
            if (done !== e.ed) begin
                errors++;
                $display("FAIL %s done: got %b want %b", name, done, e.ed);
            end
        end
    endtask

    task automatic drive_vec(input vec_t v, input string name);
        @(negedge clk);
        load       = v.ld;
        enable     = v.en;
        load_value = v.lv;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_pop(name);
    endtask

    task automatic check_now(input vec_t v, input string name);
        sb.push_back(v);
        check_pop(name);
    endtask

    initial begin
        // Reset held across two edges
        repeat (2) @(posedge clk);
        #1;
        check_now(mk(0, 0, 0, 8'd0, 1, 0, 0), "reset_hold");
        @(negedge clk);
        reset = 1'b1;

        // Idle with enable and no load: no wrap
        for (int i = 0; i < 5; i++) drive_vec(mk(0, 1, 0, 8'd0, 1, 0, 0), "idle_en");

        // One-shot count of 5
        tbl.push_back(mk(1, 1, 8'd5, 8'd5, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd4, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd3, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd2, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd1, 0, 1, 0));
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        tbl.push_back(mk(0, 1, 8'd0, 8'd5, 0, 1, 1));
        tbl.push_back(mk(1, 0, 8'd0, 8'd0, 1, 0, 0));
`else
        tbl.push_back(mk(0, 1, 8'd0, 8'd0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 8'd0, 8'd0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd0, 1, 0, 0));
`endif
        // Pause: load 10, three enabled, four held, resume
        tbl.push_back(mk(1, 0, 8'd10, 8'd10, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd9, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd8, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd7, 0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 8'd0, 8'd7, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd6, 0, 1, 0));
        // Load at the expiry cycle discards the pulse
        tbl.push_back(mk(1, 1, 8'd2, 8'd2, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 8'd4, 8'd4, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd3, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd2, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd1, 0, 1, 0));
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        tbl.push_back(mk(0, 1, 8'd0, 8'd4, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'd0, 8'd4, 0, 1, 0));
`else
        tbl.push_back(mk(0, 1, 8'd0, 8'd0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 8'd0, 8'd0, 1, 0, 0));
`endif
        // Top-of-range load and a single decrement
        tbl.push_back(mk(1, 0, 8'd255, 8'd255, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd254, 0, 1, 0));
        // Load 0 goes straight to DONE without a pulse
        tbl.push_back(mk(1, 1, 8'd0, 8'd0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'd0, 8'd0, 1, 0, 0));

        foreach (tbl[i]) drive_vec(tbl[i], $sformatf("vec%0d", i));

        // Async reset mid-count at 150
        drive_vec(mk(1, 0, 8'd200, 8'd200, 0, 1, 0), "load200");
        for (int i = 1; i <= 50; i++)
            drive_vec(mk(0, 1, 0, 8'(200 - i), 0, 1, 0), "count200");
        #2;
        reset = 1'b0;
        #1;
        check_now(mk(0, 0, 0, 8'd0, 1, 0, 0), "async_reset");
        @(negedge clk);
        reset = 1'b1;
        drive_vec(mk(1, 0, 8'd0, 8'd0, 1, 0, 0), "load0_after_reset");
        drive_vec(mk(0, 1, 8'd0, 8'd0, 1, 0, 0), "done_hold");

        // Reset clears a done pulse in flight
        drive_vec(mk(1, 0, 8'd1, 8'd1, 0, 1, 0), "load1");
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        drive_vec(mk(0, 1, 8'd0, 8'd1, 0, 1, 1), "expire1");
`else
        drive_vec(mk(0, 1, 8'd0, 8'd0, 1, 0, 1), "expire1");
`endif
        #2;
        reset = 1'b0;
        #1;
        check_now(mk(0, 0, 0, 8'd0, 1, 0, 0), "reset_clears_done");
        @(negedge clk);
        reset = 1'b1;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // Periodic pulses every 3 enabled edges
        drive_vec(mk(1, 0, 8'd3, 8'd3, 0, 1, 0), "ar_load3");
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] exp_o;
            exp_o = (i % 3 == 1) ? 8'd2 : ((i % 3 == 2) ? 8'd1 : 8'd3);
            drive_vec(mk(0, 1, 8'd0, exp_o, 0, 1, (i % 3 == 0)), "auto_reload");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable 8-bit down counter / one-shot timer; the counting-direction complement of the team's up_counter.
- Software or control logic loads a start value, gates counting with enable, and receives a single-cycle done pulse on expiry.
- Sits beside up_counter in the Counters library; used for timeouts, delay generation and terminal-count events.

Parameters:
- WIDTH, 8, counter and load-value width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, and release is sampled on clk.
- enable  input  1  count enable; decrement permitted only while high.
- load  input  1  synchronous load strobe; has priority over enable.
- load_value  input  WIDTH  start value captured when load=1.
- out  output  WIDTH  current count.
- zero  output  1  high while out==0 and the state is not RUN.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse when the count expires.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, out=0, zero=1, busy=0, done=0.
  - With AUTO_RELOAD_EN, the internal reload register is also cleared to 0.
- States: IDLE, RUN, DONE. All outputs are registered; there is no combinational path from inputs to outputs.
- Load, any state:
  - load=1 at an edge: out<=load_value, and the reload register<=load_value (feature only).
  - load_value!=0 -> RUN. load_value==0 -> DONE with no done pulse.
  - enable is ignored on a load cycle, so no decrement happens in the same cycle.
- IDLE:
  - out held at 0; enable is ignored, so there is no wrap to 2^WIDTH-1.
  - Only load leaves IDLE.
- RUN, load=0:
  - enable=1 and out>1: out<=out-1.
  - enable=1 and out==1: expiry (see below).
  - enable=0: out holds, state holds, done=0.
- Expiry without the feature:
  - out<=0, done<=1 for exactly one cycle, state->DONE.
  - The done pulse is visible in the same cycle that out first reads 0.
- DONE:
  - out held at 0, zero=1, done=0 after the pulse cycle; enable is ignored (no wrap).
  - Only load leaves DONE.
- Latency: from load, N enabled edges bring out from N to 0. Edges with enable low do not count.
- Mid-operation events:
  - load during RUN: restarts from the new load_value. A pending expiry is discarded, so no done pulse if out==1 and enable==1 in that cycle.
  - reset asserted mid-count: immediate return to the reset state; a done pulse in flight is cleared.
- Arithmetic is unsigned modulo 2^WIDTH, but the FSM guarantees out never decrements below 0.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - Expiry in RUN sets out<=reload register (not 0), pulses done for one cycle, and stays in RUN. This gives periodic done pulses every reload_value enabled cycles.
  - zero never asserts during RUN.
  - Loading 0 still goes to DONE and stops.
- Undefined: the reload register is not instantiated and expiry behaves as one-shot, as described above.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, enable=1 for 5 cycles with no load -> out=0, zero=1, busy=0, done never asserts.
- One-shot count: load_value=5 with load pulse, then enable=1 -> out 5,4,3,2,1,0 on consecutive edges; done=1 only in the cycle out becomes 0; state DONE; 3 further enabled cycles leave out=0.
- Pause: load 10, enable=1 for 3 edges (out=7), enable=0 for 4 edges -> out stays 7, busy=1; re-enable gives 6 on the next edge.
- Reload at expiry: load 2, enable=1; at out==1 assert load with load_value=4 -> out=4, no done pulse, counts 3,2,1,0 afterwards.
- Async reset mid-count: load 200, count to 150, pull reset low between edges -> out=0, busy=0 immediately, without waiting for clk; load 0 -> DONE, zero=1, done=0.
- Auto-reload (macro defined): load 3, enable=1 for 9 edges -> out 2,1,3,2,1,3,2,1,3; done pulses at edges 3, 6 and 9; busy=1 throughout.
